// File: rtl/serial_parallel_rx.sv
// Receive deserializer: hunts for a sync word in an LSB-first bit stream,
// then assembles fixed-length frames of words onto a valid/ready output.
module serial_parallel_rx #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] SYNC_WORD   = 16'hA5C3,
   parameter int unsigned      FRAME_WORDS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_signal,
   input  logic             bit_valid,
   input  logic             data_ready,
   output logic [WIDTH-1:0] parallel_data,
   output logic             data_valid,
   output logic             locked,
   output logic             sync_found,
   output logic             frame_done,
   output logic             overrun
);

   localparam int unsigned FW = $clog2(WIDTH + 1);
   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_WORDS - 1);

   typedef enum logic {
      HUNT    = 1'b0,
      ALIGNED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             sync_q, sync_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;

   logic [WIDTH-1:0] sr_nx;
   logic [FW-1:0]    fill_nx;
   logic             word_done;

   assign sr_nx   = {serial_signal, sr_q[WIDTH-1:1]};
   assign fill_nx = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      fill_d     = fill_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      sync_d     = 1'b0;
      done_d     = 1'b0;
      word_done  = 1'b0;

      if (bit_valid) begin
         sr_d = sr_nx;
         unique case (state_q)
            HUNT: begin
               fill_d = fill_nx;
               // Sliding window: every new bit re-tests the last WIDTH bits.
               if (fill_nx == FILL_FULL && sr_nx == SYNC_WORD) begin
                  state_d    = ALIGNED;
                  sync_d     = 1'b1;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
               end
            end
            ALIGNED: begin
               if (bit_cnt_q == BIT_LAST) begin
                  word_done = 1'b1;
                  bit_cnt_d = '0;
                  if (word_cnt_q == WORD_LAST) begin
                     done_d     = 1'b1;
                     state_d    = HUNT;
                     fill_d     = '0;
                     word_cnt_d = '0;
                  end else begin
                     word_cnt_d = word_cnt_q + CW'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (word_done) begin
         // A pending word being accepted this cycle frees the slot.
         if (!valid_q || data_ready) begin
            data_d  = sr_nx;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sr_q       <= '0;
         fill_q     <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sync_q     <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         fill_q     <= fill_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sync_q     <= sync_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
      end
   end

   assign parallel_data = data_q;
   assign data_valid    = valid_q;
   assign locked        = (state_q == ALIGNED);
   assign sync_found    = sync_q;
   assign frame_done    = done_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx with a queue-based frame model
// checked every cycle, plus literal expectations per scenario.
module tb_serial_parallel_rx;

   localparam int          W    = 16;
   localparam logic [15:0] SYNC = 16'hA5C3;
   localparam int          FWN  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          serial_signal;
   logic          bit_valid;
   logic          data_ready;
   logic [W-1:0]  parallel_data;
   logic          data_valid;
   logic          locked;
   logic          sync_found;
   logic          frame_done;
   logic          overrun;

   serial_parallel_rx #(
      .WIDTH(W),
      .SYNC_WORD(SYNC),
      .FRAME_WORDS(FWN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .serial_signal(serial_signal),
      .bit_valid(bit_valid),
      .data_ready(data_ready),
      .parallel_data(parallel_data),
      .data_valid(data_valid),
      .locked(locked),
      .sync_found(sync_found),
      .frame_done(frame_done),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: bit queues and the expected registered outputs.
   bit          m_aligned;
   bit          hq[$];
   bit          wq[$];
   int          m_wcnt;
   logic [15:0] e_data;
   bit          e_valid, e_sync, e_done, e_ovr;
   logic [15:0] loaded[$];
   int          n_sync, n_done, n_locked;

   function automatic logic [15:0] qval(input bit q[$]);
      logic [15:0] v;
      v = '0;
      foreach (q[i]) v[i] = q[i];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit bv, input bit b, input bit rd);
      bit          comp;
      logic [15:0] w;
      comp = 0;
      w    = '0;
      if (!r) begin
         m_aligned = 0;
         hq.delete();
         wq.delete();
         m_wcnt  = 0;
         e_data  = '0;
         e_valid = 0;
         e_sync  = 0;
         e_done  = 0;
         e_ovr   = 0;
         return;
      end
      e_sync = 0;
      e_done = 0;
      if (bv) begin
         if (!m_aligned) begin
            hq.push_back(b);
            if (hq.size() > W) void'(hq.pop_front());
            if (hq.size() == W && qval(hq) == SYNC) begin
               m_aligned = 1;
               e_sync    = 1;
               wq.delete();
               m_wcnt = 0;
            end
         end else begin
            wq.push_back(b);
            if (wq.size() == W) begin
               w    = qval(wq);
               comp = 1;
               wq.delete();
               m_wcnt++;
               if (m_wcnt == FWN) begin
                  e_done    = 1;
                  m_aligned = 0;
                  hq.delete();
               end
            end
         end
      end
      if (comp) begin
         if (!e_valid || rd) begin
            e_data  = w;
            e_valid = 1;
            loaded.push_back(w);
         end else begin
            e_ovr = 1;
         end
      end else if (e_valid && rd) begin
         e_valid = 0;
      end
   endtask

   task automatic compare();
      chk("data_valid", 32'(data_valid), 32'(e_valid));
      chk("locked", 32'(locked), 32'(m_aligned));
      chk("sync_found", 32'(sync_found), 32'(e_sync));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      if (e_valid) chk("parallel_data", 32'(parallel_data), 32'(e_data));
      if (sync_found) n_sync++;
      if (frame_done) n_done++;
      if (locked) n_locked++;
   endtask

   task automatic step(input bit r, input bit bv, input bit b, input bit rd);
      rst_n         = r;
      bit_valid     = bv;
      serial_signal = b;
      data_ready    = rd;
      @(posedge clk);
      #1;
      model(r, bv, b, rd);
      compare();
   endtask

   task automatic send_word(input logic [15:0] w, input int gap,
                            input bit rd, input bit rd_last);
      for (int i = 0; i < W; i++) begin
         step(1, 1, w[i], (i == W - 1) ? rd_last : rd);
         for (int g = 0; g < gap; g++) step(1, 0, 0, rd);
      end
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) step(1, 0, 0, rd);
   endtask

   task automatic clr_log();
      loaded.delete();
      n_sync   = 0;
      n_done   = 0;
      n_locked = 0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bit_valid     = 1'b0;
      serial_signal = 1'b0;
      data_ready    = 1'b0;
      clr_log();
      #2;

      // Reset with noisy inputs, then release with no strobes.
      for (int i = 0; i < 3; i++)
         step(0, 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_data", 32'(parallel_data), 32'h0);
      idle(3, 1);
      chk("rel_locked", 32'(locked), 32'h0);

      // Basic frame on back-to-back strobes.
      clr_log();
      send_word(SYNC, 0, 1, 1);
      send_word(16'h1234, 0, 1, 1);
      send_word(16'hBEEF, 0, 1, 1);
      idle(3, 1);
      chk("basic_nwords", 32'(loaded.size()), 32'd2);
      if (loaded.size() == 2) begin
         chk("basic_w0", 32'(loaded[0]), 32'h1234);
         chk("basic_w1", 32'(loaded[1]), 32'hBEEF);
      end
      chk("basic_nsync", 32'(n_sync), 32'd1);
      chk("basic_ndone", 32'(n_done), 32'd1);
      chk("basic_locked_cycles", 32'(n_locked), 32'd32);

      // Sliding hunt after 5 offset bits.
      clr_log();
      for (int i = 0; i < 5; i++) step(1, 1, 1'($urandom), 1);
      send_word(SYNC, 0, 1, 1);
      send_word(16'h0001, 0, 1, 1);
      send_word(16'h8000, 0, 1, 1);
      idle(2, 1);
      chk("slide_nsync", 32'(n_sync), 32'd1);
      chk("slide_nwords", 32'(loaded.size()), 32'd2);
      if (loaded.size() == 2) begin
         chk("slide_w0", 32'(loaded[0]), 32'h0001);
         chk("slide_w1", 32'(loaded[1]), 32'h8000);
      end

      // Backpressure: second word is dropped and overrun sticks.
      clr_log();
      send_word(SYNC, 0, 0, 0);
      send_word(16'h1111, 0, 0, 0);
      send_word(16'h2222, 0, 0, 0);
      idle(2, 0);
      chk("bp_data", 32'(parallel_data), 32'h1111);
      chk("bp_valid", 32'(data_valid), 32'h1);
      chk("bp_ovr", 32'(overrun), 32'h1);
      idle(1, 1);
      chk("bp_valid_clr", 32'(data_valid), 32'h0);
      chk("bp_ovr_sticky", 32'(overrun), 32'h1);

      // Accept and reload on the same cycle.
      step(0, 0, 0, 0);
      chk("acc_ovr_rst", 32'(overrun), 32'h0);
      clr_log();
      send_word(SYNC, 0, 0, 0);
      send_word(16'h1111, 0, 0, 0);
      send_word(16'h2222, 0, 0, 1);
      idle(2, 0);
      chk("acc_data", 32'(parallel_data), 32'h2222);
      chk("acc_valid", 32'(data_valid), 32'h1);
      chk("acc_ovr", 32'(overrun), 32'h0);
      idle(1, 1);

      // Reset mid-word, then a frame strobed every 3rd cycle.
      clr_log();
      send_word(SYNC, 0, 1, 1);
      for (int i = 0; i < 7; i++) step(1, 1, 1'(i & 1), 1);
      step(0, 0, 0, 1);
      chk("mid_locked", 32'(locked), 32'h0);
      chk("mid_valid", 32'(data_valid), 32'h0);
      clr_log();
      send_word(SYNC, 2, 1, 1);
      send_word(16'h0F0F, 2, 1, 1);
      send_word(16'hC0DE, 2, 1, 1);
      idle(2, 1);
      chk("gap_nwords", 32'(loaded.size()), 32'd2);
      if (loaded.size() == 2) begin
         chk("gap_w0", 32'(loaded[0]), 32'h0F0F);
         chk("gap_w1", 32'(loaded[1]), 32'hC0DE);
      end
      chk("gap_ndone", 32'(n_done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
